uart_tx_regs: RTL and testbench



---
 rtl/uart_tx_regs.sv | 215 +++++++++++++++++++++
 tb/tb_uart_tx_regs.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_regs.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS/BAUDDIV/CTRL registers,
// a byte FIFO, a bit-period-timed serialiser and a level transmit-done interrupt.
module uart_tx_regs #(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        csb_i,
  input  logic        wen_i,
  input  logic [3:0]  addr_i,
  input  logic [31:0] data_i,
  input  logic [3:0]  wmask_i,
  output logic [31:0] data_o,
  output logic        tx_o,
  output logic        irq_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  // Bus semantics: a write commits on the rising edge where csb_i=0 and
  // wen_i=0; there is no stall, every access completes in that cycle. Reads
  // are combinational and only drive data_o while csb_i=0 and wen_i=1.
  logic       wr_en;
  logic [1:0] reg_sel;
  assign wr_en   = !csb_i && !wen_i;
  assign reg_sel = addr_i[3:2];

  logic unused_bits;
  assign unused_bits = ^{addr_i[1:0], data_i[31:16], wmask_i[3:2]};

  // Control/status registers
  logic [15:0] baud_q;
  logic        enable_q;
  logic        irq_en_q;
  logic        overflow_q;

  // FIFO
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          full;
  logic          empty;
  logic          push_req;
  logic          push_ok;
  logic          pop;

  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == '0);
  assign push_req = wr_en && (reg_sel == 2'd0) && wmask_i[0];
  // A pop in the same cycle frees a slot, so a push into a full FIFO is kept.
  assign push_ok  = push_req && (!full || pop);

  // Transmit FSM state
  tx_state_t   state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [15:0] div_q, div_d;
  logic [15:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        bit_end;
  logic        irq_q;

  assign bit_end = (bit_cnt_q == div_q);

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i[7:0];
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      baud_q     <= DEFAULT_DIV;
      enable_q   <= 1'b0;
      irq_en_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (push_req && full && !pop) begin
        overflow_q <= 1'b1;
      end else if (wr_en && (reg_sel == 2'd1) && wmask_i[0] && data_i[3]) begin
        overflow_q <= 1'b0;
      end
      if (wr_en && (reg_sel == 2'd2)) begin
        if (wmask_i[0]) baud_q[7:0]  <= data_i[7:0];
        if (wmask_i[1]) baud_q[15:8] <= data_i[15:8];
      end
      if (wr_en && (reg_sel == 2'd3) && wmask_i[0]) begin
        enable_q <= data_i[0];
        irq_en_q <= data_i[1];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    div_d     = div_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_q && !empty) begin
          pop       = 1'b1;
          shift_d   = mem_q[rd_ptr_q];
          div_d     = baud_q;
          bit_cnt_d = '0;
          state_d   = START;
        end
      end
      START: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 16'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          // Chain straight into the next frame so there is no idle gap.
          if (enable_q && !empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            div_d   = baud_q;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      div_q     <= '0;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      div_q     <= div_d;
      bit_cnt_q <= bit_cnt_d;
      bit_idx_q <= bit_idx_d;
      irq_q     <= irq_en_q && empty && (state_q == IDLE);
    end
  end

  assign tx_o  = (state_q == START) ? 1'b0 :
                 (state_q == DATA)  ? shift_q[0] : 1'b1;
  assign irq_o = irq_q;

  logic [4:0] count_ext;
  assign count_ext = 5'(count_q);

  always_comb begin
    data_o = '0;
    if (!csb_i && wen_i) begin
      case (reg_sel)
        2'd1:    data_o = {19'd0, count_ext, 4'd0, overflow_q,
                           (state_q != IDLE), empty, full};
        2'd2:    data_o = {16'd0, baud_q};
        2'd3:    data_o = {30'd0, irq_en_q, enable_q};
        default: data_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_regs.sv
// Directed bench for uart_tx_regs: register access, frame timing, FIFO
// overflow and push/pop collision, enable drop, async reset and interrupt.
module tb_uart_tx_regs;

  logic        clk_i;
  logic        reset_i;
  logic        csb_i;
  logic        wen_i;
  logic [3:0]  addr_i;
  logic [31:0] data_i;
  logic [3:0]  wmask_i;
  logic [31:0] data_o;
  logic        tx_o;
  logic        irq_o;

  int n_checks;
  int n_fail;

  logic [7:0] exp_q[$];

  uart_tx_regs #(.FIFO_DEPTH(8), .DEFAULT_DIV(16'd867)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .csb_i   (csb_i),
    .wen_i   (wen_i),
    .addr_i  (addr_i),
    .data_i  (data_i),
    .wmask_i (wmask_i),
    .data_o  (data_o),
    .tx_o    (tx_o),
    .irq_o   (irq_o)
  );

  // Clock and reset
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  // Driver tasks: entered and left just after a rising edge.
  task automatic wr_reg(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
    csb_i   = 1'b0;
    wen_i   = 1'b0;
    addr_i  = a;
    data_i  = d;
    wmask_i = m;
    @(posedge clk_i);
    #1;
    csb_i   = 1'b1;
    wen_i   = 1'b1;
    wmask_i = 4'h0;
  endtask

  task automatic rd_reg(input logic [3:0] a, output logic [31:0] d);
    csb_i  = 1'b0;
    wen_i  = 1'b1;
    addr_i = a;
    #1;
    d      = data_o;
    csb_i  = 1'b1;
    addr_i = 4'h0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic check_reg(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd_reg(a, d);
    check_eq(tag, d, exp);
  endtask

  // Scoreboard: each cycle of each frame against the next expected byte.
  task automatic check_stream(input int nframes, input int div, input bit first_now);
    logic [7:0]  b;
    logic        exp_bit;
    logic [31:0] st;
    bit          skip_wait;
    skip_wait = first_now;
    for (int f = 0; f < nframes; f++) begin
      b = exp_q.pop_front();
      for (int bi = 0; bi < 10; bi++) begin
        if (bi == 0)      exp_bit = 1'b0;
        else if (bi == 9) exp_bit = 1'b1;
        else              exp_bit = b[bi-1];
        for (int c = 0; c <= div; c++) begin
          if (!skip_wait) begin
            @(posedge clk_i);
            #1;
          end
          skip_wait = 1'b0;
          check_eq($sformatf("tx_f%0d_b%0d_c%0d", f, bi, c), tx_o, exp_bit);
          if (c == 0) begin
            rd_reg(4'h4, st);
            check_eq("busy_in_frame", st[2], 1'b1);
            check_eq("irq_in_frame", irq_o, 1'b0);
          end
        end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_i  = 1'b0;
    csb_i    = 1'b1;
    wen_i    = 1'b1;
    addr_i   = 4'h0;
    data_i   = '0;
    wmask_i  = 4'h0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b1;
    idle_cycles(1);

    // Reset state
    check_eq("rst_tx", tx_o, 1'b1);
    check_eq("rst_irq", irq_o, 1'b0);
    check_reg("rst_status", 4'h4, 32'h0000_0002);
    check_reg("rst_baud", 4'h8, 32'd867);
    check_reg("rst_ctrl", 4'hC, 32'h0);
    check_reg("txdata_reads_0", 4'h0, 32'h0);
    addr_i = 4'h4;
    #1;
    check_eq("rd_csb_high", data_o, 32'h0);
    csb_i = 1'b0;
    wen_i = 1'b0;
    #1;
    check_eq("rd_during_write", data_o, 32'h0);
    csb_i = 1'b1;
    wen_i = 1'b1;

    // BAUDDIV byte masking
    wr_reg(4'h8, 32'hFFFF_ABCD, 4'b0001);
    check_reg("baud_mask_lo", 4'h8, 32'h0000_03CD);
    wr_reg(4'h8, 32'hFFFF_12FF, 4'b0010);
    check_reg("baud_mask_hi", 4'h8, 32'h0000_12CD);

    // Single 0xA5 frame, 4 clocks per bit
    wr_reg(4'h8, 32'd3, 4'b0011);
    wr_reg(4'hC, 32'h1, 4'b0001);
    wr_reg(4'h0, 32'h0000_00A5, 4'b0001);
    check_eq("tx_before_pop", tx_o, 1'b1);
    exp_q.push_back(8'hA5);
    check_stream(1, 3, 1'b0);
    idle_cycles(1);
    check_eq("a5_tx_idle", tx_o, 1'b1);
    check_reg("a5_status_end", 4'h4, 32'h0000_0002);

    // Overflow with enable off, then drain back-to-back at 1 clock per bit
    wr_reg(4'hC, 32'h0, 4'b0001);
    wr_reg(4'h8, 32'd0, 4'b0011);
    for (int i = 0; i < 9; i++) begin
      wr_reg(4'h0, 32'h10 + i, 4'b0001);
      if (i < 8) exp_q.push_back(8'(8'h10 + i));
    end
    check_reg("ovf_status", 4'h4, 32'h0000_0809);
    wr_reg(4'h4, 32'h8, 4'b0001);
    check_reg("ovf_cleared", 4'h4, 32'h0000_0801);
    check_eq("tx_idle_disabled", tx_o, 1'b1);
    wr_reg(4'hC, 32'h1, 4'b0001);
    check_stream(8, 0, 1'b0);
    idle_cycles(1);
    check_reg("drain_status_end", 4'h4, 32'h0000_0002);

    // Push into a full FIFO on the same edge as a pop
    wr_reg(4'hC, 32'h0, 4'b0001);
    for (int i = 0; i < 8; i++) begin
      wr_reg(4'h0, 32'h20 + i, 4'b0001);
      exp_q.push_back(8'(8'h20 + i));
    end
    check_reg("full_status", 4'h4, 32'h0000_0801);
    wr_reg(4'hC, 32'h1, 4'b0001);
    wr_reg(4'h0, 32'h0000_0028, 4'b0001);
    exp_q.push_back(8'h28);
    check_reg("pushpop_status", 4'h4, 32'h0000_0805);
    check_stream(9, 0, 1'b1);
    idle_cycles(1);
    check_reg("pushpop_status_end", 4'h4, 32'h0000_0002);

    // Enable dropped mid-frame: frame completes, next byte stays queued
    wr_reg(4'hC, 32'h0, 4'b0001);
    wr_reg(4'h0, 32'h41, 4'b0001);
    wr_reg(4'h0, 32'h42, 4'b0001);
    wr_reg(4'hC, 32'h1, 4'b0001);
    wr_reg(4'hC, 32'h0, 4'b0001);
    exp_q.push_back(8'h41);
    check_stream(1, 0, 1'b1);
    idle_cycles(3);
    check_reg("en_drop_status", 4'h4, 32'h0000_0100);
    check_eq("en_drop_tx", tx_o, 1'b1);

    // Asynchronous reset in the middle of the DATA phase
    wr_reg(4'h8, 32'd3, 4'b0011);
    wr_reg(4'h0, 32'h99, 4'b0001);
    wr_reg(4'hC, 32'h1, 4'b0001);
    idle_cycles(7);
    check_eq("tx_data_bit0", tx_o, 1'b0);
    #2;
    reset_i = 1'b0;
    #1;
    check_eq("async_rst_tx", tx_o, 1'b1);
    check_eq("async_rst_irq", irq_o, 1'b0);
    @(negedge clk_i);
    reset_i = 1'b1;
    idle_cycles(1);
    check_reg("post_rst_status", 4'h4, 32'h0000_0002);
    check_reg("post_rst_baud", 4'h8, 32'd867);
    check_reg("post_rst_ctrl", 4'hC, 32'h0);
    check_eq("post_rst_tx", tx_o, 1'b1);

    // Interrupt around a single 10-clock frame
    wr_reg(4'h8, 32'd0, 4'b0011);
    wr_reg(4'h0, 32'h3C, 4'b0001);
    check_eq("irq_before_en", irq_o, 1'b0);
    wr_reg(4'hC, 32'hFFFF_FFFF, 4'b0001);
    check_eq("irq_at_start", irq_o, 1'b0);
    exp_q.push_back(8'h3C);
    check_stream(1, 0, 1'b0);
    idle_cycles(1);
    check_eq("irq_first_idle", irq_o, 1'b0);
    idle_cycles(1);
    check_eq("irq_raised", irq_o, 1'b1);
    check_reg("ctrl_readback", 4'hC, 32'h0000_0003);
    wr_reg(4'hC, 32'h1, 4'b0001);
    check_eq("irq_held_one_cycle", irq_o, 1'b1);
    idle_cycles(1);
    check_eq("irq_dropped", irq_o, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
